sm4_job_sched: RTL and testbench

//  Sequencer between the UART RX block FIFO, the SM4 core and the UART TX block FIFO. Pops one
//  128-bit block, starts the core with the current mode, waits for done with a watchdog and

---
 rtl/sm4_pkg.sv | 24 ++
 rtl/sm4_wdog.sv | 40 ++++
 rtl/sm4_job_sched.sv | 181 ++++++++++++++++++
 tb/tb_sm4_job_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 UART job path.
//   SM4_BLK_W    : block width of the SM4 cipher datapath
//   MODE_ENC/DEC : encoding of the encrypt/decrypt mode bit
//   SM4_TEST_KEY : fixed key the core is built around
//   state_e      : sequencer states
package sm4_pkg;

    localparam int SM4_BLK_W = 128;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    localparam logic [127:0] SM4_TEST_KEY = 128'h0123456789abcdeffedcba9876543210;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LAT   = 3'd2,
        START = 3'd3,
        BUSY  = 3'd4,
        WB    = 3'd5
    } state_e;

endpackage

// File: rtl/sm4_wdog.sv
// Watchdog counter for the wait-for-core phase.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : restart count at zero
//   en_i       : advance one cycle
//   expire_o   : high while the count sits on its last value (TMO_CYC-1)
// The count saturates at the expiry value so expire_o stays up until cleared.
module sm4_wdog #(
    parameter int TMO_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == CW'(TMO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sm4_job_sched.sv
// Sequencer: RX block FIFO -> SM4 core -> TX block FIFO.
//   mode_tog                 : request encrypt/decrypt swap, applied only while IDLE
//   in_empty/in_rd_en/in_rdata       : RX FIFO pop side, data RD_LAT cycles after pop
//   core_en/core_mode/core_intext    : start pulse, mode and block to the core
//   core_done/core_outtext           : core completion and result
//   out_full/out_wr_en/out_wdata     : TX FIFO push side
//   mode, busy, blk_cnt              : status
//   tmo_err/err_clr                  : sticky watchdog error and its clear
// Every output comes straight from a flop; strobes are registered from the
// next state, so a strobe is high during the state it belongs to.
module sm4_job_sched
    import sm4_pkg::*;
#(
    parameter int BLK_W   = SM4_BLK_W,
    parameter int RD_LAT  = 1,
    parameter int TMO_CYC = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_tog,
    input  logic             in_empty,
    output logic             in_rd_en,
    input  logic [BLK_W-1:0] in_rdata,
    output logic             core_en,
    output logic             core_mode,
    output logic [BLK_W-1:0] core_intext,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_outtext,
    input  logic             out_full,
    output logic             out_wr_en,
    output logic [BLK_W-1:0] out_wdata,
    output logic             mode,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             tmo_err,
    input  logic             err_clr
);

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic              tog_pend_q, tog_pend_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [BLK_W-1:0]  intext_q, intext_d;
    logic [BLK_W-1:0]  wdata_q, wdata_d;
    logic              core_mode_q, core_mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              rd_en_q, rd_en_d;
    logic              core_en_q, core_en_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;

    logic              wdog_clr, wdog_en, wdog_exp;

    sm4_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wdog_clr),
        .en_i     (wdog_en),
        .expire_o (wdog_exp)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        tog_pend_d  = tog_pend_q | mode_tog;
        lat_d       = lat_q;
        intext_d    = intext_q;
        wdata_d     = wdata_q;
        core_mode_d = core_mode_q;
        cnt_d       = cnt_q;
        tmo_d       = err_clr ? 1'b0 : tmo_q;
        wr_en_d     = 1'b0;
        wdog_clr    = 1'b0;
        wdog_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // Swap takes a whole idle cycle; a toggle arriving in that
                // same cycle becomes the next pending request.
                if (tog_pend_q) begin
                    mode_d     = ~mode_q;
                    tog_pend_d = mode_tog;
                end else if (!in_empty) begin
                    state_d = RD;
                end
            end
            RD: begin
                lat_d   = '0;
                state_d = LAT;
            end
            LAT: begin
                if (lat_q == LW'(RD_LAT - 1)) begin
                    intext_d = in_rdata;
                    state_d  = START;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            START: begin
                wdog_clr = 1'b1;
                state_d  = BUSY;
            end
            BUSY: begin
                // done on the expiry cycle still completes normally
                if (core_done) begin
                    wdata_d = core_outtext;
                    state_d = WB;
                end else if (wdog_exp) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_en = 1'b1;
                end
            end
            WB: begin
                // no watchdog here: TX backpressure may last indefinitely
                if (!out_full) begin
                    wr_en_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_en_d   = (state_d == RD);
        core_en_d = (state_d == START);
        busy_d    = (state_d != IDLE);
        if (state_d == START) begin
            core_mode_d = mode_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_ENC;
            tog_pend_q  <= 1'b0;
            lat_q       <= '0;
            intext_q    <= '0;
            wdata_q     <= '0;
            core_mode_q <= MODE_ENC;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            core_en_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            tog_pend_q  <= tog_pend_d;
            lat_q       <= lat_d;
            intext_q    <= intext_d;
            wdata_q     <= wdata_d;
            core_mode_q <= core_mode_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            rd_en_q     <= rd_en_d;
            core_en_q   <= core_en_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
        end
    end

    assign in_rd_en    = rd_en_q;
    assign core_en     = core_en_q;
    assign core_mode   = core_mode_q;
    assign core_intext = intext_q;
    assign out_wr_en   = wr_en_q;
    assign out_wdata   = wdata_q;
    assign mode        = mode_q;
    assign busy        = busy_q;
    assign blk_cnt     = cnt_q;
    assign tmo_err     = tmo_q;

endmodule

// File: tb/tb_sm4_job_sched.sv
module tb_sm4_job_sched;

    localparam int BLK_W    = 128;
    localparam int TMO_CYC  = 64;
    localparam int CNT_W    = 16;
    localparam int CORE_LAT = 32;

    localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] K1 = 128'h11111111111111111111111111111111;
    localparam logic [127:0] K2 = 128'h22222222222222222222222222222222;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode_tog = 1'b0;
    logic             in_empty;
    logic             in_rd_en;
    logic [BLK_W-1:0] in_rdata = '0;
    logic             core_en;
    logic             core_mode;
    logic [BLK_W-1:0] core_intext;
    logic             core_done;
    logic [BLK_W-1:0] core_outtext;
    logic             out_full = 1'b0;
    logic             out_wr_en;
    logic [BLK_W-1:0] out_wdata;
    logic             mode;
    logic             busy;
    logic [CNT_W-1:0] blk_cnt;
    logic             tmo_err;
    logic             err_clr = 1'b0;

    sm4_job_sched #(.BLK_W(BLK_W), .RD_LAT(1), .TMO_CYC(TMO_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode_tog(mode_tog), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .in_rdata(in_rdata), .core_en(core_en),
        .core_mode(core_mode), .core_intext(core_intext), .core_done(core_done),
        .core_outtext(core_outtext), .out_full(out_full), .out_wr_en(out_wr_en),
        .out_wdata(out_wdata), .mode(mode), .busy(busy), .blk_cnt(blk_cnt),
        .tmo_err(tmo_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- RX FIFO model ----------------
    logic [127:0] rx_mem [16];
    int rx_wp = 0;
    int rx_rp = 0;
    assign in_empty = (rx_wp == rx_rp);

    always @(posedge clk) begin
        if (in_rd_en) begin
            in_rdata <= rx_mem[rx_rp % 16];
            rx_rp    <= rx_rp + 1;
        end
    end

    // ---------------- core model ----------------
    logic         core_hang = 1'b0;
    int           core_left;
    logic [127:0] core_res;

    function automatic logic [127:0] core_f(input logic [127:0] d, input logic m);
        if (m && d == PT) return CT;
        if (!m && d == CT) return PT;
        return m ? (d ^ K1) : (d ^ K2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_left    <= 0;
            core_done    <= 1'b0;
            core_outtext <= '0;
            core_res     <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_en) begin
                core_left <= CORE_LAT;
                core_res  <= core_f(core_intext, core_mode);
            end else if (core_left > 0) begin
                core_left <= core_left - 1;
                if (core_left == 1 && !core_hang) begin
                    core_done    <= 1'b1;
                    core_outtext <= core_res;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int n_rd = 0, n_en = 0, n_wr = 0, n_done = 0, cyc = 0, rd_cyc = 0, en_cyc = 0;
    logic cm_last = 1'b0;
    logic [127:0] tx_log [64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_rd_en) begin n_rd <= n_rd + 1; rd_cyc <= cyc; end
        if (core_en) begin n_en <= n_en + 1; en_cyc <= cyc; cm_last <= core_mode; end
        if (out_wr_en) begin tx_log[n_wr % 64] <= out_wdata; n_wr <= n_wr + 1; end
        if (core_done) n_done <= n_done + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [127:0] d);
        rx_mem[rx_wp % 16] = d;
        rx_wp++;
    endtask

    task automatic wait_ge(input string nm, input int sel, input int target);
        int v;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            v = (sel == 0) ? n_rd : (sel == 1) ? n_en : (sel == 2) ? n_wr : n_done;
            if (v >= target) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, count never reached %0d", nm, target);
    endtask

    task automatic pulse_tog();
        @(negedge clk); mode_tog = 1'b1;
        @(negedge clk); mode_tog = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " rd_en"},   in_rd_en, 0);
        chk({nm, " core_en"}, core_en, 0);
        chk({nm, " wr_en"},   out_wr_en, 0);
        chk({nm, " busy"},    busy, 0);
        chk({nm, " mode"},    mode, 1);
        chk({nm, " blk_cnt"}, blk_cnt, 0);
        chk({nm, " tmo_err"}, tmo_err, 0);
        chk({nm, " wdata"},   out_wdata, 0);
        chk({nm, " intext"},  core_intext, 0);
    endtask

    typedef struct {
        logic [127:0] din;
        logic         tog;
        logic         exp_mode;
        logic [127:0] exp_out;
    } vec_t;

    vec_t vt [5];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, e0, r0, d0, n;
        logic [CNT_W-1:0] c0;
        logic [127:0] exp5 [4];

        vt[0] = '{PT,      1'b0, 1'b1, CT};
        vt[1] = '{128'h0,  1'b0, 1'b1, 128'h11111111111111111111111111111111};
        vt[2] = '{CT,      1'b1, 1'b0, PT};
        vt[3] = '{{128{1'b1}}, 1'b0, 1'b0, 128'hdddddddddddddddddddddddddddddddd};
        vt[4] = '{128'h1,  1'b1, 1'b1, 128'h11111111111111111111111111111110};

        // reset state
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // table-driven jobs (T1 is entry 0)
        for (int i = 0; i < 5; i++) begin
            if (vt[i].tog) begin
                pulse_tog();
                repeat (3) @(negedge clk);
            end
            c0 = blk_cnt;
            w0 = n_wr;
            push(vt[i].din);
            wait_ge($sformatf("vec%0d wr", i), 2, w0 + 1);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d out", i), out_wdata, vt[i].exp_out);
            chk($sformatf("vec%0d core_mode", i), cm_last, vt[i].exp_mode);
            chk($sformatf("vec%0d mode", i), mode, vt[i].exp_mode);
            chk($sformatf("vec%0d cnt", i), blk_cnt, c0 + 16'd1);
            chk($sformatf("vec%0d one_wr", i), n_wr, w0 + 1);
            if (i == 0) chk("t1 rd_to_en", en_cyc - rd_cyc, 2);
        end

        // T2: toggle while busy, applied only after write-back
        e0 = n_en; w0 = n_wr;
        push(PT);
        wait_ge("t2 en", 1, e0 + 1);
        repeat (5) @(negedge clk);
        pulse_tog();
        repeat (3) @(negedge clk);
        chk("t2 mode_held_busy", mode, 1);
        chk("t2 busy", busy, 1);
        wait_ge("t2 wr", 2, w0 + 1);
        repeat (3) @(negedge clk);
        chk("t2 out_enc", out_wdata, CT);
        chk("t2 mode_after", mode, 0);
        w0 = n_wr;
        push(CT);
        wait_ge("t2 dec wr", 2, w0 + 1);
        repeat (3) @(negedge clk);
        chk("t2 out_dec", out_wdata, PT);
        chk("t2 core_mode_dec", cm_last, 0);

        // T3: TX backpressure held 100 cycles in WB
        @(negedge clk); out_full = 1'b1;
        c0 = blk_cnt; w0 = n_wr; d0 = n_done;
        push(128'h0);
        wait_ge("t3 done", 3, d0 + 1);
        repeat (100) @(negedge clk);
        chk("t3 no_push", n_wr, w0);
        chk("t3 no_tmo", tmo_err, 0);
        chk("t3 busy_wb", busy, 1);
        out_full = 1'b0;
        wait_ge("t3 wr", 2, w0 + 1);
        repeat (5) @(negedge clk);
        chk("t3 single_push", n_wr, w0 + 1);
        chk("t3 cnt", blk_cnt, c0 + 16'd1);
        chk("t3 out", out_wdata, K2);

        // T4: core never finishes -> watchdog
        core_hang = 1'b1;
        c0 = blk_cnt; w0 = n_wr;
        push(128'h5);
        n = 0;
        while (!core_en && n < 200) begin @(negedge clk); n++; end
        chk("t4 saw_core_en", core_en, 1);
        n = 0;
        while (!tmo_err && n < 200) begin @(negedge clk); n++; end
        chk("t4 tmo_cycles", n, TMO_CYC + 1);
        chk("t4 tmo_err", tmo_err, 1);
        chk("t4 idle", busy, 0);
        chk("t4 cnt_same", blk_cnt, c0);
        chk("t4 no_wr", n_wr, w0);
        core_hang = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4 tmo_sticky", tmo_err, 1);
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("t4 tmo_clr", tmo_err, 0);
        push(128'h0);
        wait_ge("t4 next wr", 2, w0 + 1);
        repeat (3) @(negedge clk);
        chk("t4 next_out", out_wdata, K2);
        chk("t4 next_cnt", blk_cnt, c0 + 16'd1);

        // T5: four blocks back-to-back
        exp5[0] = 128'h22222222222222222222222222222223;
        exp5[1] = 128'h22222222222222222222222222222220;
        exp5[2] = 128'h22222222222222222222222222222221;
        exp5[3] = 128'h22222222222222222222222222222226;
        c0 = blk_cnt; w0 = n_wr; e0 = n_en; r0 = n_rd;
        for (int i = 0; i < 4; i++) push(128'(i + 1));
        wait_ge("t5 wr", 2, w0 + 4);
        repeat (5) @(negedge clk);
        chk("t5 rd_cnt", n_rd - r0, 4);
        chk("t5 en_cnt", n_en - e0, 4);
        chk("t5 wr_cnt", n_wr - w0, 4);
        chk("t5 blk_cnt", blk_cnt - c0, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t5 out%0d", i), tx_log[(w0 + i) % 64], exp5[i]);

        // T6a: reset while BUSY (mode is 0 here)
        e0 = n_en;
        push(PT);
        wait_ge("t6 en", 1, e0 + 1);
        repeat (5) @(negedge clk);
        chk("t6 pre_mode", mode, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6 busy_rst");
        @(negedge clk); rst_n = 1'b1;

        // T6b: reset while stalled in WB
        pulse_tog();
        repeat (3) @(negedge clk);
        chk("t6 mode0", mode, 0);
        @(negedge clk); out_full = 1'b1;
        d0 = n_done;
        push(128'h0);
        wait_ge("t6 wb done", 3, d0 + 1);
        repeat (3) @(negedge clk);
        chk("t6 in_wb", busy, 1);
        w0 = n_wr;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6 wb_rst");
        @(negedge clk); rst_n = 1'b1; out_full = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6 no_stray_wr", n_wr, w0);
        chk("t6 idle_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
